// File: rtl/upload_unpacker.sv
// -----------------------------------------------------------------------------
// upload_unpacker
//   Receive-side frame decoder. Hunts for [HDR_H][HDR_L][source][len_h][len_l]
//   [data...][checksum] in a serial byte stream and validates length and
//   checksum. The payload is buffered and released on a req/valid/ready byte
//   stream tagged with the source byte, but only once the checksum matches.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   in_data/in_valid    framed input byte stream
//   in_ready            byte accepted (low only while a payload is released)
//   out_req             high for the whole payload release
//   out_source          source byte of the frame being released
//   out_data/out_valid  payload byte stream
//   out_ready           downstream accepts the byte
//   frame_ok            1-cycle pulse: good frame accepted
//   frame_err           1-cycle pulse: frame discarded
//   err_count           saturating count of discarded frames
// -----------------------------------------------------------------------------
module upload_unpacker #(
    parameter logic [7:0]  FRAME_HEADER_H = 8'hAA,
    parameter logic [7:0]  FRAME_HEADER_L = 8'h44,
    parameter int unsigned MAX_LEN        = 255,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_req,
    output logic [7:0]  out_source,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] err_count
);

    // Buffer is a power of two deep so the index is a plain bit slice.
    localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [2:0] {
        ST_HUNT1 = 3'd0,
        ST_HUNT2 = 3'd1,
        ST_SRC   = 3'd2,
        ST_LENH  = 3'd3,
        ST_LENL  = 3'd4,
        ST_DATA  = 3'd5,
        ST_CSUM  = 3'd6,
        ST_EMIT  = 3'd7
    } state_t;

    // 8-bit modular checksum accumulation.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    // Saturating 16-bit increment for the error counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_r,      state_nxt_s;
    logic [7:0]  csum_r,       csum_nxt_s;
    logic [7:0]  len_r,        len_nxt_s;
    logic [7:0]  idx_r,        idx_nxt_s;
    logic [7:0]  source_r,     source_nxt_s;
    logic [31:0] tmo_r,        tmo_nxt_s;
    logic [15:0] err_count_r,  err_count_nxt_s;
    logic        frame_ok_r,   frame_ok_nxt_s;
    logic        frame_err_r,  frame_err_nxt_s;
    logic        out_req_r,    out_req_nxt_s;
    logic        out_valid_r,  out_valid_nxt_s;
    logic [7:0]  out_data_r,   out_data_nxt_s;
    logic [7:0]  out_source_r, out_source_nxt_s;
    logic        in_ready_r,   in_ready_nxt_s;

    logic [7:0]  pay_buf_r [DEPTH];
    logic        buf_we_s;
    logic        xfer_s;
    logic        ok_s;
    logic        err_s;
    logic [7:0]  idx_inc_s;
    logic        in_frame_s;

    assign xfer_s     = in_valid && in_ready_r;
    assign idx_inc_s  = idx_r + 8'd1;
    assign in_frame_s = (state_r == ST_SRC) || (state_r == ST_LENH) || (state_r == ST_LENL) ||
                        (state_r == ST_DATA) || (state_r == ST_CSUM);

    // Next-state, datapath and output decode.
    always_comb begin
        state_nxt_s      = state_r;
        csum_nxt_s       = csum_r;
        len_nxt_s        = len_r;
        idx_nxt_s        = idx_r;
        source_nxt_s     = source_r;
        tmo_nxt_s        = tmo_r;
        out_req_nxt_s    = out_req_r;
        out_valid_nxt_s  = out_valid_r;
        out_data_nxt_s   = out_data_r;
        out_source_nxt_s = out_source_r;
        err_count_nxt_s  = err_count_r;
        buf_we_s         = 1'b0;
        ok_s             = 1'b0;
        err_s            = 1'b0;

        case (state_r)
            ST_HUNT1: begin
                if (xfer_s && (in_data == FRAME_HEADER_H)) begin
                    state_nxt_s = ST_HUNT2;
                    csum_nxt_s  = in_data;
                end else begin
                    state_nxt_s = ST_HUNT1;
                end
            end
            ST_HUNT2: begin
                if (!xfer_s) begin
                    state_nxt_s = ST_HUNT2;
                end else if (in_data == FRAME_HEADER_L) begin
                    state_nxt_s = ST_SRC;
                    csum_nxt_s  = csum_add(csum_r, in_data);
                end else if (in_data == FRAME_HEADER_H) begin
                    // A repeated first header byte may itself start the frame.
                    state_nxt_s = ST_HUNT2;
                    csum_nxt_s  = in_data;
                end else begin
                    state_nxt_s = ST_HUNT1;
                end
            end
            ST_SRC: begin
                if (xfer_s) begin
                    source_nxt_s = in_data;
                    csum_nxt_s   = csum_add(csum_r, in_data);
                    state_nxt_s  = ST_LENH;
                end else begin
                    state_nxt_s = ST_SRC;
                end
            end
            ST_LENH: begin
                if (!xfer_s) begin
                    state_nxt_s = ST_LENH;
                end else if (in_data == 8'h00) begin
                    csum_nxt_s  = csum_add(csum_r, in_data);
                    state_nxt_s = ST_LENL;
                end else begin
                    err_s = 1'b1;
                end
            end
            ST_LENL: begin
                if (!xfer_s) begin
                    state_nxt_s = ST_LENL;
                end else if ((in_data == 8'h00) || (32'(in_data) > MAX_LEN)) begin
                    err_s = 1'b1;
                end else begin
                    len_nxt_s   = in_data;
                    csum_nxt_s  = csum_add(csum_r, in_data);
                    idx_nxt_s   = 8'd0;
                    state_nxt_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    buf_we_s   = 1'b1;
                    csum_nxt_s = csum_add(csum_r, in_data);
                    idx_nxt_s  = idx_inc_s;
                    if (idx_inc_s == len_r) begin
                        state_nxt_s = ST_CSUM;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (!xfer_s) begin
                    state_nxt_s = ST_CSUM;
                end else if (in_data == csum_r) begin
                    // Release starts in the very next cycle with buffer slot 0.
                    ok_s             = 1'b1;
                    idx_nxt_s        = 8'd0;
                    state_nxt_s      = ST_EMIT;
                    out_req_nxt_s    = 1'b1;
                    out_valid_nxt_s  = 1'b1;
                    out_source_nxt_s = source_r;
                    out_data_nxt_s   = pay_buf_r[{AW{1'b0}}];
                end else begin
                    err_s = 1'b1;
                end
            end
            ST_EMIT: begin
                if (out_valid_r && out_ready) begin
                    if (idx_inc_s == len_r) begin
                        state_nxt_s      = ST_HUNT1;
                        out_req_nxt_s    = 1'b0;
                        out_valid_nxt_s  = 1'b0;
                        out_data_nxt_s   = 8'h00;
                        out_source_nxt_s = 8'h00;
                    end else begin
                        idx_nxt_s      = idx_inc_s;
                        out_data_nxt_s = pay_buf_r[idx_inc_s[AW-1:0]];
                    end
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                state_nxt_s = ST_HUNT1;
            end
        endcase

        // Inter-byte idle watchdog, only while inside a frame body.
        if ((TIMEOUT_CYCLES != 32'd0) && in_frame_s) begin
            if (in_valid) begin
                tmo_nxt_s = 32'd0;
            end else if ((tmo_r + 32'd1) == TIMEOUT_CYCLES) begin
                tmo_nxt_s = 32'd0;
                err_s     = 1'b1;
            end else begin
                tmo_nxt_s = tmo_r + 32'd1;
            end
        end else begin
            tmo_nxt_s = 32'd0;
        end

        // Any discard drops straight back to the hunt; the offending byte is consumed.
        if (err_s) begin
            state_nxt_s     = ST_HUNT1;
            err_count_nxt_s = sat_inc16(err_count_r);
        end else begin
            err_count_nxt_s = err_count_r;
        end

        frame_ok_nxt_s  = ok_s;
        frame_err_nxt_s = err_s;
        in_ready_nxt_s  = (state_nxt_s != ST_EMIT);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_HUNT1;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_r       <= 8'h00;
            len_r        <= 8'h00;
            idx_r        <= 8'h00;
            source_r     <= 8'h00;
            tmo_r        <= 32'd0;
            err_count_r  <= 16'h0000;
            frame_ok_r   <= 1'b0;
            frame_err_r  <= 1'b0;
            out_req_r    <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= 8'h00;
            out_source_r <= 8'h00;
            in_ready_r   <= 1'b1;
        end else begin
            csum_r       <= csum_nxt_s;
            len_r        <= len_nxt_s;
            idx_r        <= idx_nxt_s;
            source_r     <= source_nxt_s;
            tmo_r        <= tmo_nxt_s;
            err_count_r  <= err_count_nxt_s;
            frame_ok_r   <= frame_ok_nxt_s;
            frame_err_r  <= frame_err_nxt_s;
            out_req_r    <= out_req_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            out_data_r   <= out_data_nxt_s;
            out_source_r <= out_source_nxt_s;
            in_ready_r   <= in_ready_nxt_s;
        end
    end

    // Payload buffer; contents are only read after being written, so no reset.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            pay_buf_r[idx_r[AW-1:0]] <= in_data;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_req    = out_req_r;
    assign out_source = out_source_r;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign frame_ok   = frame_ok_r;
    assign frame_err  = frame_err_r;
    assign err_count  = err_count_r;

endmodule

// File: tb/tb_upload_unpacker.sv
`timescale 1ns/1ps
module tb_upload_unpacker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance: full-size buffer with a 16-cycle idle timeout.
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_req;
    logic [7:0]  out_source;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] err_count;

    // Small instance: MAX_LEN=4 for the length-limit boundary.
    logic [7:0]  b_in_data = 8'h00;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic        b_out_req;
    logic [7:0]  b_out_source;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic        b_frame_ok;
    logic        b_frame_err;
    logic [15:0] b_err_count;

    upload_unpacker #(.MAX_LEN(255), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_req(out_req), .out_source(out_source), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_count(err_count)
    );

    upload_unpacker #(.MAX_LEN(4), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_req(b_out_req), .out_source(b_out_source), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .frame_ok(b_frame_ok), .frame_err(b_frame_err), .err_count(b_err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: expected {source,data} bytes and event counts.
    logic [15:0] exp_q[$];
    logic [7:0]  stream[$];
    int exp_ok = 0, exp_err = 0, exp_errcnt = 0;
    int ok_seen = 0, err_seen = 0;
    int b_ok = 0, b_err = 0;
    int ready_mode = 1; // 0: hold low, 1: always high, 2: random

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level scan of a whole byte stream: which frames are good,
    // which are discarded, and what payload must come out.
    task automatic model_scan(input int max_len);
        int i, j, n, ll;
        logic [7:0] sum;
        i = 0;
        n = stream.size();
        while (i < n) begin
            if (stream[i] != 8'hAA) begin i++; continue; end
            j = i + 1;
            while (j < n && stream[j] == 8'hAA) j++;
            if (j >= n) break;
            if (stream[j] != 8'h44) begin i = j + 1; continue; end
            if (j + 3 >= n) break;
            if (stream[j+2] != 8'h00) begin
                exp_err++; exp_errcnt++; i = j + 3; continue;
            end
            ll = int'(stream[j+3]);
            if (ll == 0 || ll > max_len) begin
                exp_err++; exp_errcnt++; i = j + 4; continue;
            end
            if (j + 4 + ll >= n) break;
            sum = 8'hAA + 8'h44 + stream[j+1] + stream[j+3];
            for (int k = 0; k < ll; k++) sum = sum + stream[j+4+k];
            if (stream[j+4+ll] == sum) begin
                exp_ok++;
                for (int k = 0; k < ll; k++) exp_q.push_back({stream[j+1], stream[j+4+k]});
            end else begin
                exp_err++; exp_errcnt++;
            end
            i = j + 5 + ll;
        end
    endtask

    // Offer one byte (called just after a falling edge); returns at the
    // falling edge following the accepting rising edge.
    task automatic send(input bit on_b, input logic [7:0] b);
        int k;
        k = 0;
        if (on_b) begin b_in_data = b; b_in_valid = 1'b1; end
        else begin in_data = b; in_valid = 1'b1; end
        while (!(on_b ? b_in_ready : in_ready) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) begin
            n_checks++; n_fail++;
            $display("FAIL send_wait: in_ready stuck low for %0d cycles, required 1", k);
        end
        @(negedge clk);
        if (on_b) b_in_valid = 1'b0;
        else in_valid = 1'b0;
    endtask

    task automatic send_stream(input bit on_b);
        for (int i = 0; i < stream.size(); i++) send(on_b, stream[i]);
    endtask

    task automatic drain_and_check(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_req) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) begin
            n_checks++; n_fail++;
            $display("FAIL %s_drain: %0d bytes still pending, required 0", tag, exp_q.size());
        end
        repeat (3) @(negedge clk);
        check({tag, "_ok_count"}, ok_seen, exp_ok);
        check({tag, "_err_count"}, err_seen, exp_err);
        check({tag, "_err_counter"}, {16'd0, err_count}, exp_errcnt);
        check({tag, "_left"}, exp_q.size(), 0);
    endtask

    // Output ready generator (changes right at the falling edge).
    always begin
        @(negedge clk);
        case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
    end

    // Per-cycle compare against the model.
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic [15:0] e_word;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            check("in_ready_vs_emit", in_ready, !out_req);
            check("ok_err_exclusive", frame_ok & frame_err, 0);
            if (out_valid) check("valid_implies_req", out_req, 1);
            if (hold_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_d);
            end
            if (frame_ok) ok_seen++;
            if (frame_err) err_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL out_unexpected: got src 0x%0h data 0x%0h, required no byte", out_source, out_data);
                end else begin
                    e_word = exp_q.pop_front();
                    check("out_byte", {out_source, out_data}, e_word);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
        end
    end

    // Event counter for the small instance.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (b_frame_ok) b_ok++;
            if (b_frame_err) b_err++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        int e0;

        // Reset state
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_req", out_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_source", out_source, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_count", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Good frame with exact latency
        stream = {8'hAA, 8'h44, 8'h03, 8'h00, 8'h02, 8'h11, 8'h22, 8'h26};
        model_scan(255);
        check("model_good_n", exp_q.size(), 2);
        check("model_good_b0", exp_q[0], 16'h0311);
        check("model_good_b1", exp_q[1], 16'h0322);
        for (int i = 0; i < 7; i++) send(1'b0, stream[i]);
        send(1'b0, 8'h26);
        check("good_frame_ok", frame_ok, 1);
        check("good_first_valid", out_valid, 1);
        check("good_first_req", out_req, 1);
        check("good_source", out_source, 8'h03);
        check("good_first_data", out_data, 8'h11);
        @(negedge clk);
        check("good_second_data", out_data, 8'h22);
        check("good_second_valid", out_valid, 1);
        check("good_ok_pulse_end", frame_ok, 0);
        @(negedge clk);
        check("good_end_valid", out_valid, 0);
        check("good_end_req", out_req, 0);
        check("good_end_in_ready", in_ready, 1);
        drain_and_check("good");

        // Bad checksum then a good frame
        stream = {8'hAA, 8'h44, 8'h03, 8'h00, 8'h02, 8'h11, 8'h22, 8'h27,
                  8'hAA, 8'h44, 8'h03, 8'h00, 8'h02, 8'h11, 8'h22, 8'h26};
        model_scan(255);
        send_stream(1'b0);
        drain_and_check("badcs");
        check("badcs_err_literal", err_count, 16'd1);

        // Resync through garbage and a doubled first header byte
        e0 = exp_ok;
        stream = {8'h55, 8'hAA, 8'hAA, 8'h44, 8'h01, 8'h00, 8'h01, 8'h5A, 8'h4A};
        model_scan(255);
        check("model_resync_ok", exp_ok - e0, 1);
        check("model_resync_byte", exp_q[0], 16'h015A);
        send_stream(1'b0);
        drain_and_check("resync");

        // Length errors; the last one has len_h=AA which must not restart a frame
        stream = {8'hAA, 8'h44, 8'h05, 8'h01,
                  8'hAA, 8'h44, 8'h05, 8'h00, 8'h00,
                  8'hAA, 8'h44, 8'h05, 8'hAA, 8'h44, 8'h05, 8'h00, 8'h01, 8'h77, 8'h00};
        model_scan(255);
        send_stream(1'b0);
        drain_and_check("lenerr");
        check("lenerr_err_literal", err_count, 16'd4);

        // Small instance: len_h, len 0, len above MAX_LEN, then len == MAX_LEN
        stream = {8'hAA, 8'h44, 8'h05, 8'h01,
                  8'hAA, 8'h44, 8'h05, 8'h00, 8'h00,
                  8'hAA, 8'h44, 8'h05, 8'h00, 8'h05,
                  8'hAA, 8'h44, 8'h07, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h03};
        send_stream(1'b1);
        repeat (10) @(negedge clk);
        check("small_err_count", b_err_count, 16'd3);
        check("small_err_pulses", b_err, 3);
        check("small_ok_pulses", b_ok, 1);
        check("small_idle_req", b_out_req, 0);

        // Back-pressure: 255-byte payload, then a frame offered during release
        c = 8'hAA + 8'h44 + 8'h7E + 8'h00 + 8'hFF;
        stream = {8'hAA, 8'h44, 8'h7E, 8'h00, 8'hFF};
        for (int k = 0; k < 255; k++) begin
            stream.push_back(8'(k));
            c = c + 8'(k);
        end
        check("bp_csum_literal", c, 8'hEC);
        stream.push_back(c);
        stream.push_back(8'hAA); stream.push_back(8'h44); stream.push_back(8'h03);
        stream.push_back(8'h00); stream.push_back(8'h02); stream.push_back(8'h11);
        stream.push_back(8'h22); stream.push_back(8'h26);
        model_scan(255);
        check("model_bp_n", exp_q.size(), 257);
        ready_mode = 2;
        send_stream(1'b0);
        drain_and_check("backpressure");
        ready_mode = 1;

        // Timeout: stall after the source byte
        e0 = err_seen;
        send(1'b0, 8'hAA);
        send(1'b0, 8'h44);
        send(1'b0, 8'h09);
        repeat (15) @(negedge clk);
        check("tmo_not_yet", frame_err, 0);
        check("tmo_not_yet_count", err_seen, e0);
        @(negedge clk);
        check("tmo_fire", frame_err, 1);
        exp_err++;
        exp_errcnt++;
        stream = {8'hAA, 8'h44, 8'h03, 8'h00, 8'h02, 8'h11, 8'h22, 8'h26};
        model_scan(255);
        send_stream(1'b0);
        drain_and_check("timeout");

        // Reset during release
        ready_mode = 0;
        stream = {8'hAA, 8'h44, 8'h03, 8'h00, 8'h02, 8'h11, 8'h22, 8'h26};
        model_scan(255);
        send_stream(1'b0);
        repeat (2) @(negedge clk);
        check("emit_hold_valid", out_valid, 1);
        check("emit_hold_data", out_data, 8'h11);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_req", out_req, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_source", out_source, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_err_count", err_count, 0);
        exp_q.delete();
        exp_errcnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 1;
        @(negedge clk);
        model_scan(255);
        send_stream(1'b0);
        drain_and_check("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/upload_unpacker.md
Name: upload_unpacker

Overview:
- Receive-side counterpart of the upload packer.
- Consumes a serial byte stream of frames `[0xAA][0x44][source][len_h][len_l][data...][checksum]`, hunts for the header and validates length and checksum.
- Buffers the payload and releases it as a raw req/valid/ready byte stream tagged with the source byte, only after the checksum matches.
- Sits between a byte receiver (UART/USB RX) and command or loopback handlers; also serves as the reference checker in packer benches.

Parameters:
- FRAME_HEADER_H, 8'hAA, first header byte
- FRAME_HEADER_L, 8'h44, second header byte
- MAX_LEN, 255, largest accepted payload length (1..255); sets buffer depth
- TIMEOUT_CYCLES, 0, mid-frame inter-byte idle limit in clk cycles; 0 disables

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  framed byte stream
- in_valid  in  1  in_data valid
- in_ready  out  1  unpacker accepts byte (transfer = in_valid & in_ready)
- out_req  out  1  high for the whole payload release
- out_source  out  8  source byte of the released frame, stable while out_req=1
- out_data  out  8  payload byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts (transfer = out_valid & out_ready)
- frame_ok  out  1  1-cycle pulse: good frame accepted
- frame_err  out  1  1-cycle pulse: frame discarded
- err_count  out  16  discarded-frame counter, saturates at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0 except in_ready=1; state=HUNT1; checksum, length, indices cleared.
  - Reset mid-frame or mid-release drops everything; buffer contents need no reset.
- States: HUNT1, HUNT2, SRC, LENH, LENL, DATA, CSUM, EMIT.
- in_ready=1 in every state except EMIT. Each state advances only on an input transfer, except EMIT.
- Header hunt and resync:
  - HUNT1: byte==FRAME_HEADER_H -> HUNT2 with csum=byte; else stay.
  - HUNT2: byte==FRAME_HEADER_L -> SRC; byte==FRAME_HEADER_H -> stay in HUNT2 (csum reloaded); else -> HUNT1. No frame_err in hunt states.
- Header fields:
  - SRC: latch source, csum+=byte -> LENH.
  - LENH: byte must be 0x00, else error.
  - LENL: len=byte; len==0 or len>MAX_LEN -> error; else idx=0 -> DATA.
- Payload and checksum:
  - DATA: buf[idx]=byte, csum+=byte, idx++; after the len-th byte -> CSUM.
  - CSUM: byte==csum -> pulse frame_ok, idx=0, -> EMIT; else error.
- Checksum arithmetic: 8-bit sum mod 256 over header, source, len_h, len_l and all data bytes. The checksum byte itself is excluded.
- Error action, same cycle as the offending transfer:
  - Pulse frame_err, increment err_count (saturating), go to HUNT1.
  - The offending byte is not re-examined as a header byte.
- EMIT (release):
  - First cycle in EMIT drives out_req=1, out_valid=1, out_source=source, out_data=buf[0]. Latency: checksum byte accepted at cycle N -> out_valid at N+1.
  - Each out transfer presents buf[idx+1] in the next cycle.
  - Holding out_ready=0 holds out_data and out_valid stable (no drop, no duplicate).
  - On transfer of the len-th byte: out_req and out_valid go 0 the next cycle, state -> HUNT1, in_ready returns to 1 that same cycle.
- Input during EMIT is back-pressured (in_ready=0), so no input byte is lost.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter runs in SRC..CSUM while in_valid=0 and clears on every transfer.
  - Reaching TIMEOUT_CYCLES -> frame_err, err_count++, HUNT1. Not active in hunt states or EMIT.
- frame_ok and frame_err are never asserted in the same cycle.
- The source byte is passed through unchanged; no source filtering.

Test Plan:
- Good frame: stream AA 44 03 00 02 11 22 26, out_ready=1 -> frame_ok one cycle after 0x26; out_req high, out_source=03, outputs 11 then 22 on consecutive cycles; err_count=0.
- Bad checksum: same frame with last byte 0x27 -> frame_err pulse, err_count=1, out_req never asserts; a following good frame is released normally.
- Resync/garbage: stream 55 AA AA 44 01 00 01 5A + checksum (AA+44+01+00+01+5A = 0x4A) -> one frame_ok, output 5A with source 01, no frame_err.
- Length errors: len_h=01 -> frame_err after len_h byte; len_l=00 -> frame_err; with MAX_LEN=4, len_l=05 -> frame_err. err_count=3.
- Back-pressure: 255-byte payload 00..FE, out_ready toggling randomly -> all 255 bytes in order, none duplicated; in_ready=0 throughout EMIT; bytes offered during EMIT are accepted afterwards.
- Timeout/reset: TIMEOUT_CYCLES=16, stall 16 cycles after the source byte -> frame_err, HUNT1. Separately, assert rst_n during EMIT -> outputs 0 and in_ready=1 immediately.
